// File: rtl/pu_acc_if.sv
// Beat input and result output handshake bundle for pu_acc.
// PU_ACC_BIAS_EN adds the per-beat bias lane.
interface pu_acc_if #(
    parameter int N = 4,
    parameter int W = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [N*W-1:0]      a;
    logic [N*W-1:0]      w;
`ifdef PU_ACC_BIAS_EN
    logic signed [W-1:0] bias;
`endif
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out;

    modport master (
`ifdef PU_ACC_BIAS_EN
        output bias,
`endif
        output in_valid, a, w, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
`ifdef PU_ACC_BIAS_EN
        input  bias,
`endif
        input  in_valid, a, w, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/pu_acc.sv
// Pipelined N-channel dot-product accumulator with rescale and clamped ReLU.
// Optional PU_ACC_BIAS_EN adds a per-group bias seeded into the accumulator.
module pu_acc #(
    parameter int N     = 4,
    parameter int W     = 5,
    parameter int BEATS = 1,
    parameter int SHIFT = W - 1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     clear,
    output logic     busy,
    pu_acc_if.slave  io
);
    localparam int PW = 2 * W + $clog2(N);
    localparam int AW = PW + $clog2(BEATS) + 1;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
    localparam logic signed [AW-1:0] OMAX = AW'((1 << (W - 1)) - 1);

    logic                  stall;
    logic                  accept;
    logic                  last;
    logic                  add;

    logic                  s0_v;
    logic [N*W-1:0]        s0_a;
    logic [N*W-1:0]        s0_w;
    logic                  s1_v;
    logic signed [2*W-1:0] s1_p [N];
    logic                  s2_v;
    logic signed [PW-1:0]  s2_sum;
    logic [CW-1:0]         cnt;
    logic signed [AW-1:0]  acc;
    logic                  ov;
    logic [W-1:0]          out_q;

    logic signed [2*W-1:0] prod [N];
    logic signed [PW-1:0]  tree;
    logic signed [AW-1:0]  base;
    logic signed [AW-1:0]  acc_next;
    logic signed [AW-1:0]  shifted;
    logic [W-1:0]          act_v;

`ifdef PU_ACC_BIAS_EN
    logic signed [W-1:0]   s0_b;
    logic signed [W-1:0]   s1_b;
    logic signed [W-1:0]   s2_b;
`endif

    assign stall       = ov & ~io.out_ready;
    assign io.in_ready = ~stall & ~clear & rst;
    assign accept      = io.in_valid & io.in_ready;
    assign last        = (cnt == LAST);
    assign add         = s2_v & ~stall;
    assign busy        = s0_v | s1_v | s2_v | (cnt != '0);
    assign io.out_valid = ov;
    assign io.out       = out_q;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            prod[i] = (2*W)'($signed(s0_a[i*W +: W]))
                    * (2*W)'($signed(s0_w[i*W +: W]));
        end
    end

    always_comb begin
        tree = '0;
        for (int i = 0; i < N; i++) begin
            tree = tree + PW'(s1_p[i]);
        end
    end

    // A group starts from zero, or from the bias lifted to the product scale.
    always_comb begin
`ifdef PU_ACC_BIAS_EN
        base = (cnt == '0) ? (AW'(s2_b) <<< SHIFT) : acc;
`else
        base = (cnt == '0) ? '0 : acc;
`endif
        acc_next = base + AW'(s2_sum);
        shifted  = acc_next >>> SHIFT;
        if (shifted[AW-1]) begin
            act_v = '0;
        end else if (shifted > OMAX) begin
            act_v = OMAX[W-1:0];
        end else begin
            act_v = shifted[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_v   <= 1'b0;
            s0_a   <= '0;
            s0_w   <= '0;
            s1_v   <= 1'b0;
            for (int i = 0; i < N; i++) s1_p[i] <= '0;
            s2_v   <= 1'b0;
            s2_sum <= '0;
            cnt    <= '0;
            acc    <= '0;
            ov     <= 1'b0;
            out_q  <= '0;
`ifdef PU_ACC_BIAS_EN
            s0_b   <= '0;
            s1_b   <= '0;
            s2_b   <= '0;
`endif
        end else if (clear) begin
            s0_v <= 1'b0;
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
            ov   <= 1'b0;
        end else begin
            if (!stall) begin
                s0_v <= accept;
                if (accept) begin
                    s0_a <= io.a;
                    s0_w <= io.w;
`ifdef PU_ACC_BIAS_EN
                    s0_b <= io.bias;
`endif
                end
                s1_v <= s0_v;
                for (int i = 0; i < N; i++) s1_p[i] <= prod[i];
                s2_v   <= s1_v;
                s2_sum <= tree;
`ifdef PU_ACC_BIAS_EN
                s1_b <= s0_b;
                s2_b <= s1_b;
`endif
            end
            if (add) begin
                acc <= acc_next;
                cnt <= last ? '0 : cnt + 1'b1;
                if (last) out_q <= act_v;
            end
            if (add && last) begin
                ov <= 1'b1;
            end else if (io.out_ready) begin
                ov <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pu_acc.sv
// Directed bench for pu_acc: one DUT with BEATS=1, one with BEATS=2.
// Define PU_ACC_BIAS_EN to also exercise the bias lane.
module tb_pu_acc;
    logic clk;
    logic rst1, rst2;
    logic clear1, clear2;
    logic busy1, busy2;
    int   checks = 0;
    int   errors = 0;
    int   n_out1 = 0;
    int   n_out2 = 0;
    int   saved;

    pu_acc_if #(.N(4), .W(5)) if1 ();
    pu_acc_if #(.N(4), .W(5)) if2 ();

    pu_acc #(.N(4), .W(5), .BEATS(1), .SHIFT(4)) u1 (
        .clk(clk), .rst(rst1), .clear(clear1), .busy(busy1), .io(if1)
    );
    pu_acc #(.N(4), .W(5), .BEATS(2), .SHIFT(4)) u2 (
        .clk(clk), .rst(rst2), .clear(clear2), .busy(busy2), .io(if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (if1.out_valid && if1.out_ready) n_out1 <= n_out1 + 1;
        if (if2.out_valid && if2.out_ready) n_out2 <= n_out2 + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] rep(input int v);
        logic [4:0] e;
        e = v[4:0];
        return {4{e}};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set1(input bit v, input int av, input int wv);
        if1.in_valid = v;
        if1.a = rep(av);
        if1.w = rep(wv);
    endtask

    task automatic set2(input bit v, input int av, input int wv);
        if2.in_valid = v;
        if2.a = rep(av);
        if2.w = rep(wv);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst1 = 1'b0; rst2 = 1'b0;
        clear1 = 1'b0; clear2 = 1'b0;
        set1(0, 0, 0); set2(0, 0, 0);
        if1.out_ready = 1'b1; if2.out_ready = 1'b1;
`ifdef PU_ACC_BIAS_EN
        if1.bias = '0; if2.bias = '0;
`endif
        #2;
        chk("rst_ov1", 32'(if1.out_valid), 0);
        chk("rst_out1", 32'(if1.out), 0);
        chk("rst_busy1", 32'(busy1), 0);
        chk("rst_rdy1", 32'(if1.in_ready), 0);

        step(1);
        rst1 = 1'b1; rst2 = 1'b1;
        #1;
        chk("post_rst_rdy1", 32'(if1.in_ready), 1);
        chk("post_rst_busy2", 32'(busy2), 0);
        chk("post_rst_out2", 32'(if2.out), 0);

        // single beat, latency 3
        step(1); set1(1, 4, 4);
        step(1); set1(0, 0, 0);
        chk("b1_busy", 32'(busy1), 1);
        step(2);
        chk("b1_early_ov", 32'(if1.out_valid), 0);
        step(1);
        chk("b1_ov", 32'(if1.out_valid), 1);
        chk("b1_out", 32'(if1.out), 4);
        step(1);
        chk("b1_ov_clr", 32'(if1.out_valid), 0);
        chk("b1_idle", 32'(busy1), 0);

        // relu floor and saturation, back to back
        set1(1, -4, 4);
        step(1); set1(1, 15, 15);
        step(1); set1(0, 0, 0);
        step(2);
        chk("relu_ov", 32'(if1.out_valid), 1);
        chk("relu_out", 32'(if1.out), 0);
        step(1);
        chk("sat_ov", 32'(if1.out_valid), 1);
        chk("sat_out", 32'(if1.out), 15);
        step(1);
        chk("sat_ov_clr", 32'(if1.out_valid), 0);

        // clear drops in-flight work and refuses the same-cycle beat
        saved = n_out1;
        set1(1, 4, 4);
        step(1); clear1 = 1'b1;
        #1;
        chk("clr_rdy", 32'(if1.in_ready), 0);
        step(1); clear1 = 1'b0; set1(0, 0, 0);
        chk("clr_busy", 32'(busy1), 0);
        step(5);
        chk("clr_no_out", 32'(n_out1 - saved), 0);
        chk("clr_ov", 32'(if1.out_valid), 0);

        // backpressure with three streamed beats
        saved = n_out1;
        if1.out_ready = 1'b0;
        set1(1, 4, 4);
        step(1); set1(1, 4, 8);
        step(1); set1(1, 4, 12);
        step(1); set1(0, 0, 0);
        step(1);
        chk("st_ov", 32'(if1.out_valid), 1);
        chk("st_out", 32'(if1.out), 4);
        chk("st_rdy", 32'(if1.in_ready), 0);
        step(2);
        chk("st_hold", 32'(if1.out), 4);
        chk("st_hold_rdy", 32'(if1.in_ready), 0);
        if1.out_ready = 1'b1;
        step(1);
        chk("st_out2", 32'(if1.out), 8);
        chk("st_ov2", 32'(if1.out_valid), 1);
        step(1);
        chk("st_out3", 32'(if1.out), 12);
        step(1);
        chk("st_done", 32'(if1.out_valid), 0);
        chk("st_count", 32'(n_out1 - saved), 3);

        // BEATS=2 accumulation
        saved = n_out2;
        set2(1, 4, 4);
        step(1); set2(0, 0, 0);
        step(3);
        chk("acc_busy", 32'(busy2), 1);
        chk("acc_no_ov", 32'(if2.out_valid), 0);
        set2(1, 4, 4);
        step(1); set2(0, 0, 0);
        step(2);
        chk("acc_early", 32'(if2.out_valid), 0);
        step(1);
        chk("acc_ov", 32'(if2.out_valid), 1);
        chk("acc_out", 32'(if2.out), 8);
        step(1);
        chk("acc_idle", 32'(busy2), 0);
        chk("acc_count", 32'(n_out2 - saved), 1);

        // reset mid-group discards the partial sum
        set2(1, 4, 4);
        step(1); set2(0, 0, 0);
        step(3);
        chk("mid_busy", 32'(busy2), 1);
        rst2 = 1'b0;
        #1;
        chk("mid_rst_out", 32'(if2.out), 0);
        chk("mid_rst_busy", 32'(busy2), 0);
        chk("mid_rst_ov", 32'(if2.out_valid), 0);
        step(1);
        rst2 = 1'b1;
        set2(1, 4, 4);
        step(1); set2(1, 4, 4);
        step(1); set2(0, 0, 0);
        step(2);
        chk("mid_no_early", 32'(if2.out_valid), 0);
        step(1);
        chk("mid_ov", 32'(if2.out_valid), 1);
        chk("mid_out", 32'(if2.out), 8);
        step(1);

`ifdef PU_ACC_BIAS_EN
        if1.bias = 5'sd3;
        set1(1, 4, 4);
        step(1); set1(0, 0, 0); if1.bias = '0;
        step(3);
        chk("bias_ov", 32'(if1.out_valid), 1);
        chk("bias_out", 32'(if1.out), 7);
        step(1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pu_acc.md
PU_ACC -- requirements
Module: pu_acc

Interface
REQ-001 Parameter N, default 4: number of multiply channels, 2 or more.
REQ-002 Parameter W, default 5: width of each signed activation/weight element and of the output.
REQ-003 Parameter BEATS, default 1: number of input beats accumulated per output; 1 or more.
REQ-004 Parameter SHIFT, default W-1: arithmetic right shift applied before activation, i.e. fixed-point rescale.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 clear  input  1  synchronous abort of all in-flight work.
REQ-008 in_valid  input  1  a, w (and bias) hold a valid beat.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 a  input  N*W  N packed signed activations; channel i occupies bits [i*W +: W].
REQ-011 w  input  N*W  N packed signed weights, packed the same way as a.
REQ-012 out_valid  output  1  out holds a result.
REQ-013 out_ready  input  1  consumer takes the result this cycle.
REQ-014 out  output  W  activated result, unsigned range 0..2^(W-1)-1.
REQ-015 busy  output  1  any pipeline stage valid or partial accumulation pending.

Function
REQ-016 All arithmetic SHALL be two's complement: products are 2W bits; tree sum is PW = 2W+clog2(N) bits; accumulator is PW+clog2(BEATS)+1 bits; operands are sign-extended, never truncated.
REQ-017 A beat SHALL be accepted when in_valid and in_ready are both 1.
REQ-018 Stage S1 SHALL register the N products a_i*w_i together with a valid bit.
REQ-019 Stage S2 SHALL register the adder-tree sum of the S1 products together with a valid bit.
REQ-020 Stage S3 SHALL add the S2 sum into acc.
  - acc_next = (cnt==0 ? 0 : acc) + sum.
  - cnt counts 0..BEATS-1 and wraps to 0 after BEATS-1.
REQ-021 When an S3 add occurs with cnt==BEATS-1, out SHALL load act(acc_next) and out_valid SHALL be set.
REQ-022 act(x) SHALL be: y = x >>> SHIFT (floor); 0 if y<0; 2^(W-1)-1 if y>2^(W-1)-1; otherwise y.
REQ-023 Latency SHALL be 3 cycles: a beat accepted at edge k that completes an output sets out_valid after edge k+3.
REQ-024 Throughput SHALL be one beat per cycle when out_ready is held at 1.
REQ-025 Stall = out_valid & ~out_ready; while stalled, S1, S2, S3, cnt, acc and out SHALL hold.
REQ-026 in_ready SHALL equal ~stall & ~clear & rst.
REQ-027 A result SHALL be consumed when out_valid and out_ready are both 1; out_valid clears unless a new result loads on the same edge, in which case out updates and out_valid stays 1.
REQ-028 clear=1 SHALL, on the next edge, zero all stage valid bits, cnt, acc and out_valid; a beat presented in the same cycle is not accepted; clear overrides stall.
REQ-029 busy SHALL be 1 when any S1/S2 valid bit is 1 or cnt is non-zero.

Reset
REQ-030 While rst=0, all valid bits, cnt, acc, out and out_valid SHALL be 0 immediately, without waiting for a clock edge.
REQ-031 After reset, in_ready=1, busy=0 and out=0.
REQ-032 Reset mid-accumulation SHALL discard the partial sum; the first beat after reset starts a new group at cnt=0.

Configuration
REQ-033 Macro PU_ACC_BIAS_EN SHALL be the only compile-time option.
REQ-034 With PU_ACC_BIAS_EN defined:
  - input port bias [W-1:0] (signed) is present.
  - bias is sampled on each accepted beat and pipelined alongside its beat.
  - when cnt==0, acc_next = (sign-extended bias << SHIFT) + sum.
REQ-035 With PU_ACC_BIAS_EN undefined, the bias port SHALL be absent and behaviour is exactly REQ-020.

Verification (N=4, W=5, SHIFT=4 unless noted)
REQ-036 BEATS=1, all a=4, w=4, one beat at edge k -> out_valid=1 after edge k+3, out=4 (sum 64>>4).
REQ-037 BEATS=1, all a=-4, w=4 -> out=0 (ReLU); all a=15, w=15 (sum 900) -> out=15 (saturated).
REQ-038 BEATS=2, two beats of all a=4, w=4 -> exactly one output, out=8; busy=1 between the beats.
REQ-039 BEATS=1, out_ready=0 with 3 beats streamed -> first result held with out=4; in_ready=0 while stalled; all 3 results appear in order once out_ready=1; none lost or duplicated.
REQ-040 BEATS=2, rst pulsed low between beat 1 and beat 2 -> outputs zero immediately; next 2 beats of all a=4, w=4 -> out=8.
REQ-041 PU_ACC_BIAS_EN defined, BEATS=1, bias=3, all a=4, w=4 -> out=7 ((48+64)>>4).
